// File: rtl/nubus_pkg.sv
// Shared types and helpers for the NuBus slave-access controller.
package nubus_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_TMO = 2'b11;

  // Widest packed wait-state table the helper accepts.
  localparam int unsigned PackW = 256;

  // Returns the w-bit field at index idx of a packed table, field 0 in the LSBs.
  function automatic logic [31:0] wait_slice(input logic [PackW-1:0] vec,
                                             input int unsigned      idx,
                                             input int unsigned      w);
    return 32'(vec >> (idx * w)) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/nubus_slave_ctrl_if.sv
// Bus-side handshake bundle of the NuBus slave controller.
interface nubus_slave_ctrl_if #(
  parameter int unsigned SEL_W = 2
);
  localparam int unsigned NREG = 2 ** SEL_W;

  logic             START;
  logic             ACK;
  logic             MYSLOT;
  logic             TM1;
  logic [SEL_W-1:0] ASEL;
  logic             READY;
  logic             MSTDN;
  logic             SLAVE;
  logic             MASTER;
  logic             TM1L;
  logic [SEL_W-1:0] SELL;
  logic [NREG-1:0]  REG_OE;
  logic [NREG-1:0]  REG_WE;
  logic             ACKCY;
  logic [1:0]       STATUS;

  modport slave (
    input  START, ACK, MYSLOT, TM1, ASEL, READY, MSTDN,
    output SLAVE, MASTER, TM1L, SELL, REG_OE, REG_WE, ACKCY, STATUS
  );

  modport master (
    output START, ACK, MYSLOT, TM1, ASEL, READY, MSTDN,
    input  SLAVE, MASTER, TM1L, SELL, REG_OE, REG_WE, ACKCY, STATUS
  );

endinterface

// File: rtl/nubus_wait_timer.sv
// Loadable wait-state down-counter plus stall timeout counter.
module nubus_wait_timer #(
  parameter int unsigned WAIT_W = 4,
  parameter int unsigned TMO_W  = 6
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              run,
  input  logic              ready,
  output logic              done,
  output logic              tmo
);

  localparam logic [TMO_W-1:0] TmoLast = TMO_W'((2 ** TMO_W) - 2);

  logic [WAIT_W-1:0] cnt_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic              stall;

  // done means the counter reaches zero on this edge (or already sits there).
  assign done  = (cnt_q <= WAIT_W'(1));
  assign stall = run & done & ~ready;
  assign tmo   = stall & (tmo_cnt_q == TmoLast);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q     <= '0;
      tmo_cnt_q <= '0;
    end else if (load) begin
      cnt_q     <= load_val;
      tmo_cnt_q <= '0;
    end else if (run) begin
      if (cnt_q != '0) cnt_q <= cnt_q - WAIT_W'(1);
      if (stall)       tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

endmodule

// File: rtl/nubus_slave_ctrl.sv
// NuBus slave-access state machine: decode, wait states, READY stretch,
// timeout error and MASTER arming.
module nubus_slave_ctrl import nubus_pkg::*; #(
  parameter int unsigned                       SEL_W      = 2,
  parameter int unsigned                       WAIT_W     = 4,
  parameter logic [(2**SEL_W)*WAIT_W-1:0]      RD_WAITS   = {4'd3, 4'd1, 4'd1, 4'd1},
  parameter logic [(2**SEL_W)*WAIT_W-1:0]      WR_WAITS   = {4'd0, 4'd0, 4'd0, 4'd0},
  parameter int unsigned                       MST_REGION = 2,
  parameter int unsigned                       TMO_W      = 6
) (
  input logic                CLK,
  input logic                RESET,
  nubus_slave_ctrl_if.slave  bus
);

  localparam int unsigned NREG = 2 ** SEL_W;

  state_e            state_q, state_d;
  logic              tm1l_q;
  logic [SEL_W-1:0]  sell_q;
  logic              tmo_q, tmo_d;
  logic              master_q, master_d;
  logic              addr_cy, load, done, tmo, set_req;
  logic [WAIT_W-1:0] load_val;
  logic [NREG-1:0]   sel_hot;

  assign addr_cy = bus.START & ~bus.ACK & bus.MYSLOT;
  assign load    = (state_q == StIdle) & addr_cy;

  always_comb begin
    load_val = bus.TM1 ? WAIT_W'(wait_slice(PackW'(WR_WAITS), 32'(bus.ASEL), WAIT_W))
                       : WAIT_W'(wait_slice(PackW'(RD_WAITS), 32'(bus.ASEL), WAIT_W));
  end

  nubus_wait_timer #(
    .WAIT_W (WAIT_W),
    .TMO_W  (TMO_W)
  ) u_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (load),
    .load_val (load_val),
    .run      (state_q == StWait),
    .ready    (bus.READY),
    .done     (done),
    .tmo      (tmo)
  );

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (addr_cy) begin
          tmo_d   = 1'b0;
          state_d = ((load_val == '0) && bus.READY) ? StAck : StWait;
        end
      end
      StWait: begin
        if (tmo) begin
          tmo_d   = 1'b1;
          state_d = StAck;
        end else if (done && bus.READY) begin
          state_d = StAck;
        end
      end
      StAck: begin
        tmo_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A pending set outranks MSTDN; MSTDN only clears an already-armed MASTER.
  assign set_req = (state_q == StAck) & tm1l_q & ~tmo_q & (sell_q == SEL_W'(MST_REGION));

  always_comb begin
    master_d = master_q;
    if (set_req && !master_q)      master_d = 1'b1;
    else if (master_q && bus.MSTDN) master_d = 1'b0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      tmo_q    <= 1'b0;
      master_q <= 1'b0;
      tm1l_q   <= 1'b0;
      sell_q   <= '0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      master_q <= master_d;
      if (load) begin
        tm1l_q <= bus.TM1;
        sell_q <= bus.ASEL;
      end
    end
  end

  assign sel_hot    = NREG'(1) << sell_q;
  assign bus.SLAVE  = (state_q != StIdle);
  assign bus.MASTER = master_q;
  assign bus.TM1L   = tm1l_q;
  assign bus.SELL   = sell_q;
  assign bus.ACKCY  = (state_q == StAck);
  assign bus.STATUS = ((state_q == StAck) && tmo_q) ? ST_TMO : ST_OK;
  assign bus.REG_OE = ((state_q != StIdle) && !tm1l_q) ? sel_hot : '0;
  assign bus.REG_WE = ((state_q == StAck) && tm1l_q && !tmo_q) ? sel_hot : '0;

endmodule

// File: tb/tb_nubus_slave_ctrl.sv
// Directed bench for nubus_slave_ctrl: vector table plus multi-cycle corner sequences.
module tb_nubus_slave_ctrl;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  nubus_slave_ctrl_if #(.SEL_W(2)) b1 ();
  nubus_slave_ctrl_if #(.SEL_W(2)) b2 ();

  // Second instance with a short timeout shares the stimulus of the first.
  assign b2.START  = b1.START;
  assign b2.ACK    = b1.ACK;
  assign b2.MYSLOT = b1.MYSLOT;
  assign b2.TM1    = b1.TM1;
  assign b2.ASEL   = b1.ASEL;
  assign b2.READY  = b1.READY;
  assign b2.MSTDN  = b1.MSTDN;

  nubus_slave_ctrl dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (b1)
  );

  nubus_slave_ctrl #(.TMO_W(3)) dut_t (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (b2)
  );

  typedef struct {
    logic       st, ak, my, tm;
    logic [1:0] as;
    logic       rd, md;
    logic [15:0] exp;
  } vec_t;

  vec_t tab[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n;

  function automatic vec_t v(input logic st, ak, my, tm, input logic [1:0] as,
                             input logic rd, md,
                             input logic es, em, ea, input logic [3:0] eoe, ewe,
                             input logic [1:0] est, input logic et, input logic [1:0] esl);
    vec_t r;
    r.st = st; r.ak = ak; r.my = my; r.tm = tm; r.as = as; r.rd = rd; r.md = md;
    r.exp = {es, em, ea, eoe, ewe, est, et, esl};
    return r;
  endfunction

  function automatic logic [15:0] obs1();
    return {b1.SLAVE, b1.MASTER, b1.ACKCY, b1.REG_OE, b1.REG_WE, b1.STATUS, b1.TM1L, b1.SELL};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic st, ak, my, tm, input logic [1:0] as, input logic rd, md);
    b1.START = st; b1.ACK = ak; b1.MYSLOT = my; b1.TM1 = tm;
    b1.ASEL = as; b1.READY = rd; b1.MSTDN = md;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Each row: inputs for one cycle, then outputs expected after the following edge.
    tab.push_back(v(1,0,1,1,0,1,0, 1,0,1,4'h0,4'h1,2'd0,1,2'd0)); // write r0, no waits
    tab.push_back(v(0,0,0,0,0,1,0, 0,0,0,4'h0,4'h0,2'd0,1,2'd0));
    tab.push_back(v(1,0,1,0,3,1,0, 1,0,0,4'h8,4'h0,2'd0,0,2'd3)); // read r3, 3 waits
    tab.push_back(v(0,0,0,0,0,1,0, 1,0,0,4'h8,4'h0,2'd0,0,2'd3));
    tab.push_back(v(0,0,0,0,0,1,0, 1,0,0,4'h8,4'h0,2'd0,0,2'd3));
    tab.push_back(v(0,0,0,0,0,1,0, 1,0,1,4'h8,4'h0,2'd0,0,2'd3));
    tab.push_back(v(0,0,0,0,0,1,0, 0,0,0,4'h0,4'h0,2'd0,0,2'd3));
    tab.push_back(v(1,0,1,1,2,1,0, 1,0,1,4'h0,4'h4,2'd0,1,2'd2)); // write r2 arms MASTER
    tab.push_back(v(0,0,0,0,0,1,0, 0,1,0,4'h0,4'h0,2'd0,1,2'd2));
    tab.push_back(v(0,0,0,0,0,1,0, 0,1,0,4'h0,4'h0,2'd0,1,2'd2));
    tab.push_back(v(0,0,0,0,0,1,0, 0,1,0,4'h0,4'h0,2'd0,1,2'd2));
    tab.push_back(v(0,0,0,0,0,1,0, 0,1,0,4'h0,4'h0,2'd0,1,2'd2));
    tab.push_back(v(0,0,0,0,0,1,1, 0,0,0,4'h0,4'h0,2'd0,1,2'd2)); // MSTDN clears
    tab.push_back(v(0,0,0,0,0,1,0, 0,0,0,4'h0,4'h0,2'd0,1,2'd2));
    tab.push_back(v(1,0,1,1,2,1,0, 1,0,1,4'h0,4'h4,2'd0,1,2'd2));
    tab.push_back(v(0,0,0,0,0,1,0, 0,1,0,4'h0,4'h0,2'd0,1,2'd2));
    tab.push_back(v(1,0,1,1,2,1,0, 1,1,1,4'h0,4'h4,2'd0,1,2'd2)); // rewrite while armed
    tab.push_back(v(0,0,0,0,0,1,0, 0,1,0,4'h0,4'h0,2'd0,1,2'd2));
    tab.push_back(v(1,0,1,1,0,1,0, 1,1,1,4'h0,4'h1,2'd0,1,2'd0)); // slave served in MASTER
    tab.push_back(v(0,0,0,0,0,1,1, 0,0,0,4'h0,4'h0,2'd0,1,2'd0));
    tab.push_back(v(1,0,1,1,2,1,0, 1,0,1,4'h0,4'h4,2'd0,1,2'd2));
    tab.push_back(v(0,0,0,0,0,1,1, 0,1,0,4'h0,4'h0,2'd0,1,2'd2)); // set beats MSTDN
    tab.push_back(v(0,0,0,0,0,1,1, 0,0,0,4'h0,4'h0,2'd0,1,2'd2));
    tab.push_back(v(1,0,0,0,1,1,0, 0,0,0,4'h0,4'h0,2'd0,1,2'd2)); // not my slot
    tab.push_back(v(1,1,1,0,1,1,0, 0,0,0,4'h0,4'h0,2'd0,1,2'd2)); // ACK during START
    tab.push_back(v(1,0,1,0,3,1,0, 1,0,0,4'h8,4'h0,2'd0,0,2'd3)); // read r3
    tab.push_back(v(1,0,1,1,0,1,0, 1,0,0,4'h8,4'h0,2'd0,0,2'd3)); // START in WAIT ignored
    tab.push_back(v(0,0,0,0,0,1,0, 1,0,0,4'h8,4'h0,2'd0,0,2'd3));
    tab.push_back(v(0,0,0,0,0,1,0, 1,0,1,4'h8,4'h0,2'd0,0,2'd3));
    tab.push_back(v(0,0,0,0,0,1,0, 0,0,0,4'h0,4'h0,2'd0,0,2'd3));
    tab.push_back(v(1,0,1,0,1,1,0, 1,0,0,4'h2,4'h0,2'd0,0,2'd1)); // read r1, 1 wait
    tab.push_back(v(0,0,0,0,0,1,0, 1,0,1,4'h2,4'h0,2'd0,0,2'd1));
    tab.push_back(v(0,0,0,0,0,1,0, 0,0,0,4'h0,4'h0,2'd0,0,2'd1));

    RESET = 1'b1;
    drive(0,0,0,0,0,1,0);
    step();
    chk("reset_state", 32'(obs1()), 32'h0);
    RESET = 1'b0;
    step();

    for (int i = 0; i < tab.size(); i++) begin
      drive(tab[i].st, tab[i].ak, tab[i].my, tab[i].tm, tab[i].as, tab[i].rd, tab[i].md);
      step();
      chk($sformatf("row%0d", i), 32'(obs1()), 32'(tab[i].exp));
    end

    // Short-timeout instance: read r1 with READY stuck low.
    drive(1,0,1,0,1,0,0);
    step();
    drive(0,0,0,0,0,0,0);
    n = 1;
    while (!b2.ACKCY && n < 20) begin
      step();
      n++;
    end
    chk("tmo_rd_cycle", 32'(n), 32'd8);
    chk("tmo_rd_status", 32'(b2.STATUS), 32'd3);
    chk("tmo_rd_oe", 32'(b2.REG_OE), 32'h2);
    step();
    // Write r2 timing out: no strobe and MASTER must stay clear.
    drive(1,0,1,1,2,0,0);
    step();
    drive(0,0,0,0,0,0,0);
    n = 1;
    while (!b2.ACKCY && n < 20) begin
      step();
      n++;
    end
    chk("tmo_wr_cycle", 32'(n), 32'd8);
    chk("tmo_wr_status", 32'(b2.STATUS), 32'd3);
    chk("tmo_wr_we", 32'(b2.REG_WE), 32'h0);
    step();
    chk("tmo_wr_master", 32'({b2.MASTER, b2.SLAVE}), 32'h0);

    RESET = 1'b1;
    drive(0,0,0,0,0,1,0);
    step();
    RESET = 1'b0;
    step();

    // Main instance: read r1 with READY low for 10 cycles after the address cycle.
    drive(1,0,1,0,1,1,0);
    step();
    drive(0,0,0,0,0,0,0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stretch_c%0d", i + 1), 32'(b1.ACKCY), 32'd0);
      step();
    end
    b1.READY = 1'b1;
    chk("stretch_c11", 32'({b1.SLAVE, b1.ACKCY}), 32'h2);
    step();
    chk("stretch_ack", 32'({b1.ACKCY, b1.STATUS, b1.REG_OE}), {27'd0, 1'b1, 2'b00, 4'h2});
    step();
    chk("stretch_end", 32'(b1.SLAVE), 32'd0);

    // Reset in the middle of a WAIT on read r3.
    drive(1,0,1,0,3,1,0);
    step();
    drive(0,0,0,0,0,1,0);
    step();
    chk("pre_reset_wait", 32'(obs1()), 32'({1'b1, 1'b0, 1'b0, 4'h8, 4'h0, 2'd0, 1'b0, 2'd3}));
    RESET = 1'b1;
    #1;
    chk("async_reset", 32'(obs1()), 32'h0);
    step();
    RESET = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (b1.ACKCY || b1.SLAVE) n++;
    end
    chk("no_stray_ack", 32'(n), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nubus_slave_ctrl.md
Name: nubus_slave_ctrl

Overview:
- Parametrised NuBus slave-access state machine for the test card.
- Decodes a slave cycle addressed to this slot and latches the transfer mode and the region-select address bits.
- Drives a one-hot per-region output enable and inserts a per-region, per-direction programmable number of wait states. An optional local READY stretches the cycle; a timeout terminates it with error status.
- Arms a MASTER mode on a write to a designated trigger region; MASTER holds until the master engine reports done.

Parameters:
- SEL_W, 2, number of latched address bits selecting the region; NREG = 2**SEL_W regions.
- WAIT_W, 4, width of each wait-state count.
- RD_WAITS, {4'd3,4'd1,4'd1,4'd1}, packed NREG*WAIT_W; read wait states per region, region 0 in the LSBs.
- WR_WAITS, {4'd0,4'd0,4'd0,4'd0}, packed NREG*WAIT_W; write wait states per region.
- MST_REGION, 2, region whose write arms MASTER.
- TMO_W, 6, timeout counter width; timeout fires after 2**TMO_W-1 wait cycles.

Ports:
- CLK  in  1  NuBus clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  bus START, active-high internal polarity.
- ACK  in  1  bus ACK observed, active-high.
- MYSLOT  in  1  slot-ID match.
- TM1  in  1  transfer mode; 1 = write, 0 = read.
- ASEL  in  SEL_W  region-select address bits (AD19..AD18 equivalent).
- READY  in  1  local device ready; tie high if unused.
- MSTDN  in  1  master engine done.
- SLAVE  out  1  slave cycle in progress.
- MASTER  out  1  master mode armed.
- TM1L  out  1  latched TM1.
- SELL  out  SEL_W  latched ASEL.
- REG_OE  out  NREG  one-hot region enable, reads only.
- REG_WE  out  NREG  one-hot single-cycle write strobe, asserted in the ACK cycle.
- ACKCY  out  1  drive bus ACK this cycle.
- STATUS  out  2  bus status during ACKCY: 00 = ok, 11 = timeout error.

Behaviour:
- Reset: every output and register is 0; the state machine is in IDLE.
- Address cycle is START & ~ACK & MYSLOT.

IDLE:
- On an address cycle: latch TM1L and SELL, load the wait counter from RD_WAITS or WR_WAITS at the selected region, clear the timeout counter.
- SLAVE = 1 from the next cycle. On a read, REG_OE[ASEL] = 1 from the next cycle.
- If the loaded count is 0 and READY is high, go directly to ACK; otherwise go to WAIT.

WAIT:
- Decrement the wait counter each cycle.
- When the counter is 0 and READY is high, go to ACK.
- The timeout counter increments while the wait counter is 0 and READY is low. At saturation, go to ACK with STATUS = 11.

ACK:
- ACKCY = 1 for exactly one cycle. STATUS = 00, or 11 after a timeout.
- For a write, REG_WE[SELL] = 1 in this cycle, unless a timeout occurred.
- Next cycle: SLAVE, REG_OE and ACKCY drop to 0; return to IDLE.

Latency:
- Minimum write: address cycle at edge N, ACKCY high in cycle N+1.
- Read: ACKCY high in cycle N+1+RD_WAITS[sel].

Other rules:
- START with MYSLOT during a non-IDLE state is ignored; there is no re-latch.
- TM1L and SELL hold until the next address cycle.
- MASTER:
  - Set in the cycle after ACK of a successful write with SELL == MST_REGION while MASTER = 0.
  - Clears on MSTDN.
  - If MSTDN arrives in the same cycle as a set request, the set wins: MSTDN is ignored until MASTER = 1.
  - Slave cycles are still serviced while MASTER = 1.
- Reset asserted mid-cycle: immediate return to IDLE and all outputs 0. No ACKCY is generated after RESET deasserts for the aborted cycle.
- NREG = 1 (SEL_W = 0) is not supported; SEL_W must be ≥ 1.

Decomposition:
- Package nubus_pkg: state enum (IDLE, WAIT, ACK), STATUS codes (ST_OK = 2'b00, ST_TMO = 2'b11), helper function selecting a WAIT_W slice from a packed vector.
- One natural sub-module: nubus_wait_timer, containing the loadable down-counter plus the timeout counter, with outputs done and tmo.

Test Plan:
- Write, region 0, WR_WAITS 0: START/MYSLOT/TM1 = 1, ASEL = 0 at cycle 0 -> cycle 1: SLAVE = 1, ACKCY = 1, REG_WE = 4'b0001, STATUS = 00; cycle 2: all 0.
- Read, region 3, RD_WAITS 3: address cycle at cycle 0 -> REG_OE = 4'b1000 in cycles 1-4, ACKCY only in cycle 4, SLAVE low in cycle 5.
- Read, region 1, READY held low 10 cycles after the waits expire -> ACKCY delayed accordingly, STATUS = 00; with READY stuck low and TMO_W = 3 -> ACKCY after 7 stall cycles with STATUS = 11 and no REG_WE.
- Write to region 2 -> MASTER = 1 the cycle after ACKCY; MSTDN pulse 5 cycles later -> MASTER = 0 next cycle; a second region-2 write while MASTER = 1 leaves MASTER at 1.
- MYSLOT = 0, or ACK = 1 during START -> no SLAVE, no ACKCY; a second START during WAIT is ignored and SELL is unchanged.
- RESET pulsed in the middle of a WAIT -> all outputs 0 on the same edge; no stray ACKCY after RESET falls.
